// File: rtl/secure_reg_pkg.sv
// Shared types and policy helpers for the secure register initiator.
// Only SECURE_TID may access the register; every other id is reported as denied.
package secure_reg_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_e;

  localparam int unsigned SECURE_TID = 0;

  function automatic logic tid_denied(input int unsigned tid);
    return (tid != SECURE_TID);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the pointer names the highest-priority requester and
// moves to the slot after the winner whenever a grant is issued.
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             found;
  int               idx;

  // Scan from the pointer upwards, wrapping, and take the first requester.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = int'(ptr_q) + off;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      if (!found && req[idx]) begin
        found     = 1'b1;
        grant_idx = IDX_W'(idx);
      end
    end
    if (en && found) begin
      grant[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (en && found) begin
      ptr_d = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/secure_reg_initiator.sv
// Sequences per-thread register requests onto a single thread-gated secure
// register: arbitrate, present for one cycle, capture read data, respond.
module secure_reg_initiator
  import secure_reg_pkg::*;
#(
  parameter  int NUM_THREADS = 4,
  parameter  int DATA_WIDTH  = 32,
  localparam int TID_W       = $clog2(NUM_THREADS)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_THREADS-1:0]            req_valid,
  output logic [NUM_THREADS-1:0]            req_ready,
  input  logic [NUM_THREADS-1:0]            req_wr,
  input  logic [NUM_THREADS*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_THREADS-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]             rsp_data,
  output logic                              rsp_err,
  output logic                              reg_access_en,
  output logic                              reg_wr_en,
  output logic [TID_W-1:0]                  reg_thread_id,
  output logic [DATA_WIDTH-1:0]             reg_data_in,
  input  logic [DATA_WIDTH-1:0]             reg_data_out
);

  state_e                 state_q, state_d;
  logic [TID_W-1:0]       tid_q, tid_d;
  logic                   wr_q, wr_d;
  logic                   access_en_q, access_en_d;
  logic                   wr_en_q, wr_en_d;
  logic [TID_W-1:0]       reg_tid_q, reg_tid_d;
  logic [DATA_WIDTH-1:0]  data_in_q, data_in_d;
  logic [NUM_THREADS-1:0] rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]  rsp_data_q, rsp_data_d;
  logic                   rsp_err_q, rsp_err_d;
  logic                   arb_en;
  logic                   granted;
  logic [TID_W-1:0]       grant_idx;

  assign arb_en  = (state_q == IDLE);
  assign granted = arb_en && (|req_valid);

  rr_arbiter #(
    .NUM_REQ (NUM_THREADS)
  ) u_arbiter (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req_valid),
    .en        (arb_en),
    .grant     (req_ready),
    .grant_idx (grant_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (granted) state_d = ACCESS;
      ACCESS:  state_d = CAPTURE;
      CAPTURE: state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus and response outputs are registered, so their next values are
  // computed one state early; the bus defaults to zero so nothing lingers.
  always_comb begin
    tid_d       = tid_q;
    wr_d        = wr_q;
    access_en_d = 1'b0;
    wr_en_d     = 1'b0;
    reg_tid_d   = '0;
    data_in_d   = '0;
    rsp_valid_d = '0;
    rsp_data_d  = '0;
    rsp_err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (granted) begin
          tid_d       = grant_idx;
          wr_d        = req_wr[grant_idx];
          access_en_d = 1'b1;
          wr_en_d     = req_wr[grant_idx];
          reg_tid_d   = grant_idx;
          data_in_d   = req_wdata[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
        end
      end
      CAPTURE: begin
        rsp_valid_d = NUM_THREADS'(1) << tid_q;
        rsp_err_d   = tid_denied(int'(tid_q));
        // Writes and denied accesses never leak register contents.
        rsp_data_d  = (!wr_q && !tid_denied(int'(tid_q))) ? reg_data_out : '0;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tid_q       <= '0;
      wr_q        <= 1'b0;
      access_en_q <= 1'b0;
      wr_en_q     <= 1'b0;
      reg_tid_q   <= '0;
      data_in_q   <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      tid_q       <= tid_d;
      wr_q        <= wr_d;
      access_en_q <= access_en_d;
      wr_en_q     <= wr_en_d;
      reg_tid_q   <= reg_tid_d;
      data_in_q   <= data_in_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign reg_access_en = access_en_q;
  assign reg_wr_en     = wr_en_q;
  assign reg_thread_id = reg_tid_q;
  assign reg_data_in   = data_in_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_data      = rsp_data_q;
  assign rsp_err       = rsp_err_q;

endmodule
